// File: rtl/cgra_cfg_pkg.sv
// Shared constants for the CGRA configuration bus: opcodes, address word
// field positions and the readback value returned for a bad register index.
package cgra_cfg_pkg;

    localparam logic [7:0] CFG_OP_NOP         = 8'h00;
    localparam logic [7:0] CFG_OP_WRITE       = 8'h01;
    localparam logic [7:0] CFG_OP_READ        = 8'h02;
    localparam logic [7:0] CFG_OP_COMMIT      = 8'h03;
    localparam logic [7:0] CFG_OP_READ_SHADOW = 8'h04;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 24;
    localparam int IDX_MSB  = 23;
    localparam int IDX_LSB  = 16;
    localparam int TILE_MSB = 15;
    localparam int TILE_LSB = 0;

    localparam logic [31:0] CFG_BAD_READ = 32'hDEAD_BEEF;

endpackage

// File: rtl/cgra_cfg_decode.sv
// Combinational decode of one configuration bus address word for this tile.
// All opcode strobes are already qualified by the tile hit.
module cgra_cfg_decode
    import cgra_cfg_pkg::*;
#(
    parameter logic [15:0] TILE_ID  = 16'h0000,
    parameter int          NUM_REGS = 8
) (
    input  logic [31:0] addr,
    output logic        hit,
    output logic        op_write,
    output logic        op_read,
    output logic        op_commit,
    output logic        op_read_shadow,
    output logic        idx_legal,
    output logic        is_illegal
);

    logic [7:0]  opcode;
    logic [7:0]  idx;
    logic [15:0] tile;

    assign opcode = addr[OP_MSB:OP_LSB];
    assign idx    = addr[IDX_MSB:IDX_LSB];
    assign tile   = addr[TILE_MSB:TILE_LSB];

    // Tile match, per-opcode strobes and the unknown-opcode flag
    always_comb begin
        hit            = (tile == TILE_ID);
        op_write       = hit && (opcode == CFG_OP_WRITE);
        op_read        = hit && (opcode == CFG_OP_READ);
        op_commit      = hit && (opcode == CFG_OP_COMMIT);
        op_read_shadow = hit && (opcode == CFG_OP_READ_SHADOW);
        idx_legal      = ({24'd0, idx} < 32'(NUM_REGS));
        is_illegal     = hit && !(opcode inside {CFG_OP_NOP, CFG_OP_WRITE, CFG_OP_READ,
                                                 CFG_OP_COMMIT, CFG_OP_READ_SHADOW});
    end

endmodule

// File: rtl/cgra_config_responder.sv
// Tile-side configuration endpoint: double-buffered register bank (shadow
// written by WRITE, copied to active on COMMIT), registered readback and a
// saturating count of rejected commands addressed to this tile.
module cgra_config_responder
    import cgra_cfg_pkg::*;
#(
    parameter logic [15:0] TILE_ID  = 16'h0000,
    parameter int          NUM_REGS = 8,
    parameter int          ERR_W    = 8
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [31:0]           config_addr_in,
    input  logic [31:0]           config_data_in,
    output logic [32*NUM_REGS-1:0] config_out,
    output logic [31:0]           read_data_out,
    output logic                  read_valid_out,
    output logic                  commit_out,
    output logic [ERR_W-1:0]      err_count_out
);

    // Only the low index bits are needed to address the bank; out-of-range
    // indices are caught by idx_legal before any array access matters.
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic        hit;
    logic        op_write;
    logic        op_read;
    logic        op_commit;
    logic        op_read_shadow;
    logic        idx_legal;
    logic        is_illegal;
    logic        any_read;
    logic        err_inc;
    logic [IW-1:0] widx;

    logic [31:0] shadow [NUM_REGS];
    logic [31:0] active [NUM_REGS];

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    cgra_cfg_decode #(
        .TILE_ID  (TILE_ID),
        .NUM_REGS (NUM_REGS)
    ) u_decode (
        .addr           (config_addr_in),
        .hit            (hit),
        .op_write       (op_write),
        .op_read        (op_read),
        .op_commit      (op_commit),
        .op_read_shadow (op_read_shadow),
        .idx_legal      (idx_legal),
        .is_illegal     (is_illegal)
    );

    assign widx     = config_addr_in[IDX_LSB +: IW];
    assign any_read = op_read | op_read_shadow;
    assign err_inc  = is_illegal | ((op_write | any_read) & ~idx_legal);

    // Shadow bank: takes WRITE data; survives COMMIT
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
        end else if (op_write && idx_legal) begin
            shadow[widx] <= config_data_in;
        end
    end

    // Active bank: whole-bank atomic copy from shadow on COMMIT
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_REGS; i++) active[i] <= '0;
        end else if (op_commit) begin
            active <= shadow;
        end
    end

    // Registered readback and commit pulses; read data holds between reads
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            read_data_out  <= '0;
            read_valid_out <= 1'b0;
            commit_out     <= 1'b0;
        end else begin
            read_valid_out <= any_read;
            commit_out     <= op_commit;
            if (any_read) begin
                if (!idx_legal)   read_data_out <= CFG_BAD_READ;
                else if (op_read) read_data_out <= active[widx];
                else              read_data_out <= shadow[widx];
            end
        end
    end

    // Saturating count of rejected commands
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            err_count_out <= '0;
        end else if (err_inc) begin
            err_count_out <= sat_inc(err_count_out);
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cfg_out
        assign config_out[32*i +: 32] = active[i];
    end

endmodule

// File: tb/tb_cgra_config_responder.sv
// Scoreboard bench for cgra_config_responder: the driver pushes expected read
// responses and commit pulses (with their due cycle) into queues; a monitor
// pops and compares whenever the DUT pulses read_valid_out or commit_out.
module tb_cgra_config_responder;

    localparam logic [15:0] TID      = 16'h0005;
    localparam int          NREG     = 8;
    localparam int          EW       = 8;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_WR  = 8'h01;
    localparam logic [7:0] OP_RD  = 8'h02;
    localparam logic [7:0] OP_CM  = 8'h03;
    localparam logic [7:0] OP_RS  = 8'h04;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rd_exp_t;

    logic                 clk;
    logic                 rst;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic [32*NREG-1:0]   config_out;
    logic [31:0]          read_data_out;
    logic                 read_valid_out;
    logic                 commit_out;
    logic [EW-1:0]        err_count_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    rd_exp_t rd_q[$];
    int      cm_q[$];

    logic [31:0] m_shadow [NREG];
    logic [31:0] m_active [NREG];
    int          m_err;

    cgra_config_responder #(
        .TILE_ID  (TID),
        .NUM_REGS (NREG),
        .ERR_W    (EW)
    ) dut (
        .clk_in         (clk),
        .reset_in       (rst),
        .config_addr_in (addr),
        .config_data_in (wdata),
        .config_out     (config_out),
        .read_data_out  (read_data_out),
        .read_valid_out (read_valid_out),
        .commit_out     (commit_out),
        .err_count_out  (err_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] m_flat();
        logic [255:0] f = '0;
        for (int i = 0; i < NREG; i++) f[32*i +: 32] = m_active[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_err = 0;
        rd_q.delete();
        cm_q.delete();
    endtask

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    // Drive one bus word on the falling edge and update the reference model
    task automatic issue(input logic [7:0] op, input logic [7:0] idx,
                         input logic [15:0] tile, input logic [31:0] d);
        rd_exp_t e;
        @(negedge clk);
        addr  = {op, idx, tile};
        wdata = d;
        if (tile == TID) begin
            e.cyc = cyc + 1;
            case (op)
                OP_NOP: ;
                OP_WR: if (idx < NREG) m_shadow[idx] = d; else bump_err();
                OP_RD, OP_RS: begin
                    if (idx < NREG) e.data = (op == OP_RD) ? m_active[idx] : m_shadow[idx];
                    else begin
                        e.data = 32'hDEAD_BEEF;
                        bump_err();
                    end
                    rd_q.push_back(e);
                end
                OP_CM: begin
                    for (int i = 0; i < NREG; i++) m_active[i] = m_shadow[i];
                    cm_q.push_back(cyc + 1);
                end
                default: bump_err();
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(OP_NOP, 8'd0, 16'd0, 32'd0);
    endtask

    // Monitor: compare every response pulse against the scoreboard
    initial begin
        rd_exp_t e;
        int      c;
        forever begin
            @(posedge clk);
            #1;
            if (read_valid_out) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got valid data %0h expected no response", read_data_out);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_data", 256'(read_data_out), 256'(e.data));
                    check("rd_cycle", 256'(cyc), 256'(e.cyc));
                end
            end
            if (commit_out) begin
                if (cm_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL commit_unexpected: got commit_out=1 expected 0");
                end else begin
                    c = cm_q.pop_front();
                    check("commit_cycle", 256'(cyc), 256'(c));
                end
            end
        end
    end

    initial begin
        addr  = '0;
        wdata = '0;
        rst   = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_cfg", 256'(config_out), 256'd0);
        check("rst_err", 256'(err_count_out), 256'd0);
        check("rst_rd", 256'(read_data_out), 256'd0);
        check("rst_pulses", 256'({read_valid_out, commit_out}), 256'd0);
        rst = 1'b0;

        // Reset mid-stream after WRITE + COMMIT
        issue(OP_WR, 8'd2, TID, 32'h0000_1234);
        issue(OP_CM, 8'd0, TID, 32'd0);
        issue(OP_RD, 8'd2, TID, 32'd0);
        issue(OP_RD, 8'd2, TID, 32'd0);
        idle(1);
        check("pre_rst_cfg", 256'(config_out[95:64]), 256'h1234);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_cfg", 256'(config_out), 256'd0);
        check("mid_rst_err", 256'(err_count_out), 256'd0);
        check("mid_rst_pulses", 256'({read_valid_out, commit_out}), 256'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(OP_RS, 8'd2, TID, 32'd0);
        idle(1);

        // WRITE stays in shadow until COMMIT
        issue(OP_WR, 8'd1, TID, 32'hCAFE_0001);
        issue(OP_RD, 8'd1, TID, 32'd0);
        issue(OP_RS, 8'd1, TID, 32'd0);
        idle(1);
        check("no_commit_cfg", 256'(config_out), 256'd0);
        issue(OP_CM, 8'd0, TID, 32'd0);
        issue(OP_RD, 8'd1, TID, 32'd0);
        idle(2);
        check("commit_cfg1", 256'(config_out[63:32]), 256'hCAFE_0001);

        // Other tile ignored
        issue(OP_WR, 8'd0, TID + 16'd1, 32'h5555_AAAA);
        issue(OP_RD, 8'd0, TID + 16'd1, 32'd0);
        issue(OP_CM, 8'd0, TID, 32'd0);
        idle(2);
        check("other_tile_cfg0", 256'(config_out[31:0]), 256'd0);
        check("other_tile_err", 256'(err_count_out), 256'd0);

        // Bad index and unknown opcode
        issue(OP_WR, 8'd8, TID, 32'h1111_2222);
        issue(8'h7F, 8'd0, TID, 32'h3333_4444);
        idle(1);
        check("err_two", 256'(err_count_out), 256'd2);
        issue(OP_CM, 8'd0, TID, 32'd0);
        idle(1);
        check("bad_no_change", 256'(config_out), m_flat());
        issue(OP_RD, 8'd9, TID, 32'd0);
        idle(1);
        check("err_three", 256'(err_count_out), 256'd3);

        // Saturation
        for (int i = 0; i < 300; i++) issue(8'hA5, 8'(i), TID, 32'd0);
        idle(1);
        check("err_sat", 256'(err_count_out), 256'd255);
        check("err_sat_model", 256'(err_count_out), 256'(m_err));

        // Back-to-back stream
        for (int i = 0; i < NREG; i++) issue(OP_WR, 8'(i), TID, 32'(i + 1));
        issue(OP_CM, 8'd0, TID, 32'd0);
        for (int i = 0; i < NREG; i++) issue(OP_RD, 8'(i), TID, 32'd0);
        idle(2);
        check("stream_cfg", 256'(config_out),
              256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        check("stream_err", 256'(err_count_out), 256'd255);

        // Drain: every expected pulse must have arrived
        for (int i = 0; i < 20 && (rd_q.size() != 0 || cm_q.size() != 0); i++) idle(1);
        check("drain_rd", 256'(rd_q.size()), 256'd0);
        check("drain_commit", 256'(cm_q.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cgra_config_responder.md
Name: cgra_config_responder

Overview:
Tile-side endpoint of the global CGRA configuration bus (config_addr_in/config_data_in) that the system testbench drives one word per cycle. Decodes address words aimed at this tile, writes a double-buffered register bank (shadow, then atomic commit to active), and answers readback requests with a registered response. Instantiated once per tile under top; its active-bank outputs drive the tile's switch-box and PE configuration.

Parameters:
TILE_ID, 16'h0000, tile identifier matched against config_addr_in[15:0]
NUM_REGS, 8, number of 32-bit config registers; legal range 1..256
ERR_W, 8, width of the saturating error counter

Ports:
clk_in  input  1  system clock; all state updates on rising edge
reset_in  input  1  asynchronous, active-high reset
config_addr_in  input  32  [31:24] opcode, [23:16] register index, [15:0] tile id
config_data_in  input  32  write data; ignored for non-write opcodes
config_out  output  32*NUM_REGS  active bank, flattened; register i at [32*i+31:32*i]
read_data_out  output  32  readback data
read_valid_out  output  1  one-cycle pulse qualifying read_data_out
commit_out  output  1  one-cycle pulse, high the cycle after a commit is applied
err_count_out  output  ERR_W  saturating count of rejected commands addressed to this tile

Behaviour:
- Reset: clock and reset are as stated in Ports (single clock clk_in; reset_in asynchronous, active-high). While reset_in is high, all shadow and active registers, read_data_out, read_valid_out, commit_out and err_count_out are 0. Reset mid-operation discards uncommitted shadow data and any pending read response.
- Inputs are sampled on the rising edge. The driver changes them on the falling edge, so no input synchronisation is needed.
- Hit condition: config_addr_in[15:0] == TILE_ID. On a non-hit, state is unchanged and no pulse is produced.
- Opcode 8'h00, NOP: no effect, even on a hit. The all-zero address word is the bus idle value.
- Opcode 8'h01, WRITE: if idx < NUM_REGS, shadow[idx] <= config_data_in. If idx >= NUM_REGS, no write and err_count_out increments.
- Opcode 8'h02, READ: if idx < NUM_REGS, the next cycle gives read_data_out = active[idx] and read_valid_out = 1. Latency is exactly 1 cycle. If idx >= NUM_REGS, the next cycle gives read_data_out = 32'hDEAD_BEEF, read_valid_out = 1, and err_count_out increments.
- Opcode 8'h03, COMMIT: active <= shadow for all registers in the same edge. commit_out = 1 the following cycle. Shadow is retained, not cleared.
- Opcode 8'h04, READ_SHADOW: same as READ but returns shadow[idx].
- Any other opcode on a hit: no state change, err_count_out increments.
- read_data_out holds its last value when read_valid_out = 0. read_valid_out and commit_out are single-cycle pulses.
- Back-to-back commands are accepted every cycle; there is no backpressure. A READ in the cycle immediately after a COMMIT returns the committed value.
- Error counter saturates at 2^ERR_W-1 with no wrap.
- config_out changes only on COMMIT or reset, never on WRITE.

Decomposition:
- Shared package cgra_cfg_pkg holds:
  - opcode constants CFG_OP_NOP/WRITE/READ/COMMIT/READ_SHADOW
  - field slice constants (OP_MSB/LSB, IDX_MSB/LSB, TILE_MSB/LSB)
  - CFG_BAD_READ = 32'hDEAD_BEEF
- One sub-module is natural: cgra_cfg_decode. It is purely combinational: from the address word and TILE_ID it produces hit, per-opcode strobes, idx_legal and is_illegal. The top module holds the banks, the response register and the counter.

Test Plan:
1. Reset asserted mid-stream, 3 cycles after WRITE idx 2 data 32'h1234 and COMMIT -> config_out, err_count_out and pulses are all 0 immediately; a READ_SHADOW idx 2 after release returns 0.
2. WRITE (TILE_ID, idx 1, 32'hCAFE0001), then READ idx 1 -> read_data_out = 0 with read_valid_out for 1 cycle; COMMIT, then READ idx 1 -> 32'hCAFE0001, and commit_out pulses 1 cycle after COMMIT.
3. WRITE to tile TILE_ID+1 idx 0, then COMMIT on own tile -> config_out[31:0] stays 0; err_count_out stays 0.
4. WRITE idx NUM_REGS (8) and opcode 8'h7F on own tile -> err_count_out = 2, no register changed; READ idx 9 -> 32'hDEADBEEF with valid, err_count_out = 3.
5. 300 consecutive illegal opcodes with ERR_W=8 -> err_count_out saturates at 255.
6. Back-to-back stream: WRITE idx 0..7 with values i+1, COMMIT, then READ idx 0..7 on consecutive cycles -> 8 consecutive valid pulses returning 1..8 in order, each 1 cycle after its request.
